// File: rtl/switch_event_arbiter.sv
// Serialises debounced switch level changes into one-at-a-time events over a
// valid/ready handshake, sharing simultaneous changes with a round-robin pointer.
module switch_event_arbiter #(
    parameter int NUM_SW = 18,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_db,
    input  logic              en,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [IDX_W-1:0]  ev_idx,
    output logic              ev_level,
    output logic [NUM_SW-1:0] sw_state,
    output logic [NUM_SW-1:0] pending,
    output logic [CNT_W-1:0]  ev_count
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t            state;
    logic [NUM_SW-1:0] sw_q;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  winner;

    // First requester at or after start, wrapping round to 0. Rotating the
    // doubled request vector turns the circular scan into a lowest-set-bit search.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SW-1:0] req,
                                                 input logic [IDX_W-1:0]  start);
        logic [NUM_SW-1:0] rot;
        int                off;
        int                j;
        rot = NUM_SW'({req, req} >> start);
        off = 0;
        for (int k = NUM_SW - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        j = int'(start) + off;
        if (j >= NUM_SW) j = j - NUM_SW;
        return IDX_W'(j);
    endfunction

    assign pending = sw_q ^ sw_state;
    assign winner  = rr_pick(pending, ptr);

    // The input register keeps sampling through reset so the baseline captured
    // into sw_state and the value held in sw_q agree on the first free cycle.
    always_ff @(posedge clk) begin
        sw_q <= sw_db;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_state <= sw_db;
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_idx   <= '0;
            ev_level <= 1'b0;
            ptr      <= '0;
            ev_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && (|pending)) begin
                        ev_idx   <= winner;
                        ev_level <= sw_q[winner];
                        ev_valid <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    // The offer stays frozen even if the switch reverts; the
                    // revert shows up as fresh pending state after the accept.
                    if (ev_ready) begin
                        sw_state[ev_idx] <= ev_level;
                        ev_count         <= ev_count + CNT_W'(1);
                        ptr              <= (ev_idx == IDX_W'(NUM_SW - 1)) ? '0
                                                                           : ev_idx + IDX_W'(1);
                        ev_valid         <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Randomised and directed bench for switch_event_arbiter; a transaction-level
// model predicts events into a scoreboard that an independent monitor drains.
module tb_switch_event_arbiter;

    localparam int NUM_SW = 18;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_SW-1:0] sw_db;
    logic              en;
    logic              ev_ready;
    logic              ev_valid;
    logic [IDX_W-1:0]  ev_idx;
    logic              ev_level;
    logic [NUM_SW-1:0] sw_state;
    logic [NUM_SW-1:0] pending;
    logic [CNT_W-1:0]  ev_count;

    switch_event_arbiter #(.NUM_SW(NUM_SW), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_db    (sw_db),
        .en       (en),
        .ev_ready (ev_ready),
        .ev_valid (ev_valid),
        .ev_idx   (ev_idx),
        .ev_level (ev_level),
        .sw_state (sw_state),
        .pending  (pending),
        .ev_count (ev_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic lvl;
    } ev_t;

    int  tests  = 0;
    int  errors = 0;
    ev_t exp_q[$];
    int  acc_log[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: what the switch image, report image, pointer and count
    // must be, stepped once per clock using the rules on bit arrays.
    bit                model_ok = 1'b0;
    logic [NUM_SW-1:0] m_swq;
    logic [NUM_SW-1:0] m_rep;
    int                m_ptr;
    int                m_cnt;
    bit                m_busy;
    int                m_idx;
    logic              m_lvl;

    always @(negedge clk) begin
        logic [NUM_SW-1:0] pend;
        if (model_ok) begin
            check("ev_valid", 32'(ev_valid), 32'(m_busy));
            check("sw_state", 32'(sw_state), 32'(m_rep));
            check("pending", 32'(pending), 32'(m_swq ^ m_rep));
            check("ev_count", 32'(ev_count), 32'(m_cnt % (1 << CNT_W)));
            if (m_busy) begin
                check("held_idx", 32'(ev_idx), 32'(m_idx));
                check("held_level", 32'(ev_level), 32'(m_lvl));
            end
        end
        // Advance to the state after the coming rising edge.
        if (rst) begin
            m_swq  = sw_db;
            m_rep  = sw_db;
            m_ptr  = 0;
            m_cnt  = 0;
            m_busy = 1'b0;
            exp_q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            pend = m_swq ^ m_rep;
            if (m_busy) begin
                if (ev_ready) begin
                    m_rep[m_idx] = m_lvl;
                    m_cnt++;
                    m_ptr  = (m_idx + 1) % NUM_SW;
                    m_busy = 1'b0;
                end
            end else if (en && pend != '0) begin
                for (int k = 0; k < NUM_SW; k++) begin
                    int j;
                    j = (m_ptr + k) % NUM_SW;
                    if (!m_busy && pend[j]) begin
                        m_idx  = j;
                        m_lvl  = m_swq[j];
                        m_busy = 1'b1;
                    end
                end
                exp_q.push_back('{idx: m_idx, lvl: m_lvl});
            end
            m_swq = sw_db;
        end
    end

    // Monitor: every handshake the DUT completes must match the next prediction.
    always @(negedge clk) begin
        ev_t e;
        if (model_ok && !rst && ev_valid === 1'b1 && ev_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_event: got idx %0d level %0d, expected no event at %0t",
                         ev_idx, ev_level, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_idx", 32'(ev_idx), 32'(e.idx));
                check("event_level", 32'(ev_level), 32'(e.lvl));
            end
            acc_log.push_back(int'(ev_idx));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [NUM_SW-1:0] base);
        rst   = 1'b1;
        sw_db = base;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        sw_db    = 18'h2A5A5;
        en       = 1'b1;
        ev_ready = 1'b0;

        // Reset baseline generates no events.
        do_reset(18'h2A5A5);
        ev_ready = 1'b1;
        step(20);
        check("baseline_state", 32'(sw_state), 32'h2A5A5);
        check("baseline_count", 32'(ev_count), 32'd0);

        // Single toggle on switch 3 from an all-zero baseline.
        do_reset('0);
        step(2);
        sw_db[3] = 1'b1;
        step(6);
        check("single_count", 32'(ev_count), 32'd1);
        check("single_state", 32'(sw_state), 32'h8);

        // Serve switch 16 so the pointer sits at 17, then three at once.
        sw_db[16] = 1'b1;
        step(6);
        acc_log.delete();
        sw_db[0]  = 1'b1;
        sw_db[5]  = 1'b1;
        sw_db[17] = 1'b1;
        step(10);
        check("rr_events", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            check("rr_first", 32'(acc_log[0]), 32'd17);
            check("rr_second", 32'(acc_log[1]), 32'd0);
            check("rr_third", 32'(acc_log[2]), 32'd5);
        end
        check("rr_count", 32'(ev_count), 32'd5);

        // Backpressure with the switch reverting under a held offer.
        ev_ready = 1'b0;
        sw_db[7] = 1'b1;
        step(3);
        sw_db[7] = 1'b0;
        step(10);
        check("bp_idx", 32'(ev_idx), 32'd7);
        check("bp_level", 32'(ev_level), 32'd1);
        ev_ready = 1'b1;
        step(6);
        check("bp_count", 32'(ev_count), 32'd7);
        check("bp_state7", 32'(sw_state[7]), 32'd0);

        // en gating holds changes as pending.
        en       = 1'b0;
        sw_db[2] = ~sw_db[2];
        sw_db[9] = ~sw_db[9];
        step(5);
        check("gate_pending", 32'(pending), 32'h204);
        en = 1'b1;
        step(8);
        check("gate_count", 32'(ev_count), 32'd9);

        // Reset while an offer for switch 4 is outstanding.
        ev_ready = 1'b0;
        sw_db[4] = 1'b1;
        step(3);
        check("mid_offer_valid", 32'(ev_valid), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ev_ready = 1'b1;
        step(10);
        check("mid_reset_count", 32'(ev_count), 32'd0);
        check("mid_reset_state4", 32'(sw_state[4]), 32'd1);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3, 0) == 0)
                sw_db = sw_db ^ (NUM_SW'(1) << $urandom_range(NUM_SW - 1, 0));
            if ($urandom_range(15, 0) == 0)
                sw_db = sw_db ^ NUM_SW'($urandom);
            en       = ($urandom_range(7, 0) != 0);
            ev_ready = ($urandom_range(2, 0) != 0);
            rst      = ($urandom_range(299, 0) == 0);
            step(1);
        end

        // Drain: with inputs still and the consumer ready, everything empties.
        rst      = 1'b0;
        en       = 1'b1;
        ev_ready = 1'b1;
        step(2 * NUM_SW + 10);
        check("drain_pending", 32'(pending), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/switch_event_arbiter.md
# switch_event_arbiter

Turns the 18 debounced slide-switch levels into a serialized stream of switch-change events. One event is presented at a time over a valid/ready handshake to the game/control logic. Simultaneous changes are shared fairly by a round-robin arbiter. The block sits directly downstream of the switch debouncer bank and keeps the authoritative "last reported" switch image.

## Interface
- NUM_SW, 18, number of switches arbitrated (2..32)
- IDX_W, 5, width of event index; must satisfy 2^IDX_W >= NUM_SW
- CNT_W, 16, width of accepted-event counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- sw_db  in  NUM_SW  debounced switch levels
- en  in  1  1 = new events may be offered; 0 = hold off (pending changes retained)
- ev_ready  in  1  consumer accepts current event
- ev_valid  out  1  event offered
- ev_idx  out  IDX_W  switch index of offered event
- ev_level  out  1  new level of that switch
- sw_state  out  NUM_SW  last reported level per switch
- pending  out  NUM_SW  sw_q ^ sw_state, combinational from registers
- ev_count  out  CNT_W  number of accepted events, wraps modulo 2^CNT_W

## Operation
- Input register sw_q <= sw_db every cycle, including during reset.
- Reset (rst=1 at edge): sw_q <= sw_db, sw_state <= sw_db, state <= IDLE, ev_valid <= 0, ev_idx <= 0, ev_level <= 0, ptr <= 0, ev_count <= 0.
- Switch positions at reset are therefore the baseline and generate no events.
- pending[i] = sw_q[i] != sw_state[i]. A switch that toggles and returns before being served produces no event. Every reported event is a true level change relative to the last report.
- States:
  - IDLE: if en=1 and pending != 0, select winner w (see below); at the edge, ev_idx <= w, ev_level <= sw_q[w], ev_valid <= 1, go to OFFER. Otherwise stay.
  - OFFER: ev_idx, ev_level and ev_valid are held stable until ev_valid & ev_ready at an edge. On accept:
    - sw_state[ev_idx] <= ev_level
    - ev_count <= ev_count + 1
    - ptr <= (ev_idx == NUM_SW-1) ? 0 : ev_idx+1
    - ev_valid <= 0, go to IDLE
- Round-robin select: first set bit of pending scanning ptr, ptr+1, …, NUM_SW-1, then 0, …, ptr-1.
- Switch reverts while its event is offered: the offer is not altered or withdrawn. After accept, sw_state differs from sw_q again, so a new event with the reverted level follows. No change is lost or reordered per switch.
- en is sampled only in IDLE. Dropping en during OFFER does not cancel the current offer.
- ev_ready is ignored when ev_valid=0.
- Reset mid-offer: the offer is dropped (ev_valid=0 after the edge), unreported changes are discarded, and the baseline is re-captured from sw_db.

## Timing
- sw_db change setup before edge N: sw_q updated at N; ev_valid=1 after edge N+1 (2-cycle latency, IDLE, en=1).
- Accept at edge M: ev_valid=0 after M. The next offer is registered at M+1, so ev_valid=1 after M+1. That gives one bubble cycle per event, with a maximum throughput of 1 event per 2 cycles.
- ev_ready held high continuously: k simultaneous changes are delivered in 2k cycles.
- pending and sw_state reflect the registered values; sw_state updates at the accept edge.

## Test plan
- Reset baseline: sw_db=18'h2A5A5 during rst, release, hold 20 cycles → ev_valid stays 0, sw_state=18'h2A5A5, pending=0, ev_count=0.
- Single toggle: from 0, set sw_db[3]=1 before edge N, ev_ready=1 → ev_valid high after N+1 with ev_idx=3, ev_level=1; accepted at N+2; sw_state[3]=1, ev_count=1.
- Round-robin and wrap: ptr at 17 after serving switch 16; set bits 0, 5, 17 simultaneously → events in order 17, 0, 5; ptr ends at 6; ev_count increments by 3.
- Backpressure and revert: ev_ready=0, raise sw_db[7] → offer idx 7, level 1 held unchanged for 10 cycles while sw_db[7] returns to 0; assert ev_ready → accept (7,1), then a new offer (7,0) 2 cycles later.
- en gating: en=0, toggle switches 2 and 9 → no ev_valid, pending=bits 2 and 9; set en=1 → events 2 then 9.
- Reset mid-offer: offer (4,1) pending with ev_ready=0, pulse rst with sw_db[4]=1 → ev_valid=0, sw_state[4]=1, no event for switch 4 afterward, ev_count=0.
